muldiv_sequencer: RTL and testbench

Multi-cycle controller for the multiply/divide group of data-processing operations: MUL, MLA, MLS, UMULL, UMLAL, SMULL, SMLAL, UDIV and SDIV. It sits beside the execute-stage ALU and captures operands when one of these operations enters execute. It runs a radix-2 shift-add (multiply) or restoring shift-subtract (divide) iteration, and holds the pipeline through a stall line until the result is ready. Results, flags and a high-word write strobe go to the memory-stage register file write path.

---
 rtl/muldiv_pkg.sv | 33 +++
 rtl/muldiv_sequencer_if.sv | 30 +++
 rtl/muldiv_iter_step.sv | 28 ++
 rtl/muldiv_sequencer.sv | 156 +++++++++++++++
 tb/tb_muldiv_sequencer.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer: op codes, FSM states
// and op-class predicates.
package muldiv_pkg;

  localparam logic [5:0] OP_MUL   = 6'b100111;
  localparam logic [5:0] OP_MLA   = 6'b101000;
  localparam logic [5:0] OP_MLS   = 6'b101001;
  localparam logic [5:0] OP_UMULL = 6'b101010;
  localparam logic [5:0] OP_UMLAL = 6'b101011;
  localparam logic [5:0] OP_SMULL = 6'b101100;
  localparam logic [5:0] OP_SMLAL = 6'b101101;
  localparam logic [5:0] OP_UDIV  = 6'b101110;
  localparam logic [5:0] OP_SDIV  = 6'b101111;

  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} mdState_t;

  function automatic logic is_muldiv(input logic [5:0] code);
    return (code >= OP_MUL) && (code <= OP_SDIV);
  endfunction

  function automatic logic is_long(input logic [5:0] code);
    return code inside {OP_UMULL, OP_UMLAL, OP_SMULL, OP_SMLAL};
  endfunction

  function automatic logic is_signed(input logic [5:0] code);
    return code inside {OP_SMULL, OP_SMLAL, OP_SDIV};
  endfunction

  function automatic logic is_div(input logic [5:0] code);
    return code inside {OP_UDIV, OP_SDIV};
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Execute-stage request / memory-stage result bundle of the multiply/divide
// sequencer; master is the pipeline side, slave is the sequencer.
interface muldiv_sequencer_if #(parameter int XLEN = 32);

  logic            StartE;
  logic            FlushE;
  logic [5:0]      ALUControlE;
  logic [XLEN-1:0] SrcAE;
  logic [XLEN-1:0] SrcBE;
  logic [XLEN-1:0] AccLoE;
  logic [XLEN-1:0] AccHiE;
  logic            StallMD;
  logic            DoneM;
  logic [XLEN-1:0] ResultLoM;
  logic [XLEN-1:0] ResultHiM;
  logic            HiWriteM;
  logic [1:0]      FlagsM;
  logic            DivByZeroM;

  modport master (
    output StartE, FlushE, ALUControlE, SrcAE, SrcBE, AccLoE, AccHiE,
    input  StallMD, DoneM, ResultLoM, ResultHiM, HiWriteM, FlagsM, DivByZeroM
  );

  modport slave (
    input  StartE, FlushE, ALUControlE, SrcAE, SrcBE, AccLoE, AccHiE,
    output StallMD, DoneM, ResultLoM, ResultHiM, HiWriteM, FlagsM, DivByZeroM
  );

endinterface

// File: rtl/muldiv_iter_step.sv
// One radix-2 iteration: add-shift for multiply ({hi, multiplier}) or
// restoring subtract-shift for divide ({remainder, quotient}).
module muldiv_iter_step #(parameter int XLEN = 32) (
  input  logic              isDiv,
  input  logic [2*XLEN-1:0] accIn,
  input  logic [XLEN-1:0]   operand,
  output logic [2*XLEN-1:0] accOut
);

  logic [XLEN:0]   addSum;
  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] subDiff;

  // NOTE: every output of a combinational block gets a default first so no
  // path through it can leave a value held (which would infer a latch).
  always_comb begin
    addSum  = {1'b0, accIn[2*XLEN-1:XLEN]} + (accIn[0] ? {1'b0, operand} : '0);
    shifted = accIn[2*XLEN-1:XLEN-1];
    subDiff = {1'b0, shifted} - {2'b00, operand};
    accOut  = {addSum, accIn[XLEN-1:1]};
    if (isDiv) begin
      // A borrow means the divisor did not fit: restore and shift in a 0.
      if (subDiff[XLEN+1]) accOut = {shifted[XLEN-1:0], accIn[XLEN-2:0], 1'b0};
      else                 accOut = {subDiff[XLEN-1:0], accIn[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle multiply/divide controller beside the execute-stage ALU.
// Optional MULDIV_EARLY_TERM_EN: multiplies stop iterating once the remaining multiplier bits are zero.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic             clk,
  input logic             reset,
  muldiv_sequencer_if.slave bus
);

  localparam int CW = $clog2(XLEN);

  mdState_t          state, stateNext;
  logic [5:0]        op;
  logic [XLEN-1:0]   opA, opB;
  logic [2*XLEN-1:0] accC, prod, stepNext, iterProd;
  logic [CW-1:0]     count;
  logic              negRes, negRem, divZero;
  logic [XLEN-1:0]   resLo, resHi;
  logic [1:0]        flags;

  logic              validStart, iterLast, iterExit, prepDivZero;
  logic [XLEN-1:0]   absA, absB, quot, rem;
  logic [2*XLEN-1:0] mulVal;
  logic [XLEN-1:0]   fixLo, fixHi;
  logic              fixN, fixZ;

  assign validStart  = bus.StartE && is_muldiv(bus.ALUControlE);
  assign absA        = (is_signed(op) && opA[XLEN-1]) ? -opA : opA;
  assign absB        = (is_signed(op) && opB[XLEN-1]) ? -opB : opB;
  assign prepDivZero = is_div(op) && (opB == '0);
  assign iterLast    = (count == CW'(XLEN-1));

  muldiv_iter_step #(.XLEN(XLEN)) u_step (
    .isDiv   (is_div(op)),
    .accIn   (prod),
    .operand (is_div(op) ? opB : opA),
    .accOut  (stepNext)
  );

`ifdef MULDIV_EARLY_TERM_EN
  logic multRestZero;
  // Multiplier bits above the one just consumed are all zero: the remaining
  // iterations would only shift, so do the whole shift now and leave.
  assign multRestZero = (opB >> ({1'b0, count} + (CW+1)'(1))) == '0;
  assign iterExit     = iterLast || (!is_div(op) && multRestZero);
  assign iterProd     = (iterExit && !is_div(op)) ? (stepNext >> (CW'(XLEN-1) - count))
                                                  : stepNext;
`else
  assign iterExit = iterLast;
  assign iterProd = stepNext;
`endif

  // NOTE: the state register uses non-blocking assignment so every flop
  // samples the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (validStart && !bus.FlushE) stateNext = PREP;
      PREP:    stateNext = prepDivZero ? FIX : ITER;
      ITER:    if (iterExit) stateNext = FIX;
      FIX:     stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (state != IDLE && bus.FlushE) stateNext = IDLE;
  end

  // Result shaping: sign fix-up, accumulate, divide quotient/remainder select.
  always_comb begin
    mulVal = negRes ? -prod : prod;
    quot   = negRes ? -prod[XLEN-1:0] : prod[XLEN-1:0];
    rem    = negRem ? -prod[2*XLEN-1:XLEN] : prod[2*XLEN-1:XLEN];
    fixHi  = mulVal[2*XLEN-1:XLEN];
    fixLo  = mulVal[XLEN-1:0];
    case (op)
      OP_MLA:             fixLo = accC[XLEN-1:0] + mulVal[XLEN-1:0];
      OP_MLS:             fixLo = accC[XLEN-1:0] - mulVal[XLEN-1:0];
      OP_UMLAL, OP_SMLAL: {fixHi, fixLo} = accC + mulVal;
      OP_UDIV, OP_SDIV: begin
        fixLo = quot;
        fixHi = rem;
      end
      default: ;
    endcase
    fixN = is_long(op) ? fixHi[XLEN-1] : fixLo[XLEN-1];
    fixZ = is_long(op) ? ({fixHi, fixLo} == '0) : (fixLo == '0);
  end

  // NOTE: datapath registers are reset as well as control, because the
  // result outputs must read zero straight out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op      <= '0;
      opA     <= '0;
      opB     <= '0;
      accC    <= '0;
      prod    <= '0;
      count   <= '0;
      negRes  <= 1'b0;
      negRem  <= 1'b0;
      divZero <= 1'b0;
      resLo   <= '0;
      resHi   <= '0;
      flags   <= '0;
    end else begin
      case (state)
        IDLE: if (validStart && !bus.FlushE) begin
          op    <= bus.ALUControlE;
          opA   <= bus.SrcAE;
          opB   <= bus.SrcBE;
          accC  <= {bus.AccHiE, bus.AccLoE};
          count <= '0;
        end
        PREP: begin
          opA     <= absA;
          opB     <= absB;
          negRes  <= is_signed(op) && (opA[XLEN-1] ^ opB[XLEN-1]);
          negRem  <= is_signed(op) && opA[XLEN-1];
          divZero <= prepDivZero;
          // Divide by zero: quotient 0, dividend left as remainder.
          if (prepDivZero)     prod <= {absA, XLEN'(0)};
          else if (is_div(op)) prod <= {XLEN'(0), absA};
          else                 prod <= {XLEN'(0), absB};
        end
        ITER: begin
          prod  <= iterProd;
          count <= count + CW'(1);
        end
        FIX: if (!bus.FlushE) begin
          resLo <= fixLo;
          resHi <= fixHi;
          flags <= {fixN, fixZ};
        end
        default: ;
      endcase
    end
  end

  assign bus.StallMD    = (state == IDLE && validStart && !bus.FlushE)
                        || (state inside {PREP, ITER, FIX});
  assign bus.DoneM      = (state == DONE);
  assign bus.HiWriteM   = (state == DONE) && is_long(op);
  assign bus.DivByZeroM = (state == DONE) && divZero;
  assign bus.ResultLoM  = resLo;
  assign bus.ResultHiM  = resHi;
  assign bus.FlagsM     = flags;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: the driver pushes model results,
// a negedge monitor pops and compares whenever DoneM is seen.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  localparam int XLEN = 32;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  muldiv_sequencer_if #(.XLEN(XLEN)) bus();
  muldiv_sequencer #(.XLEN(XLEN)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  typedef struct {
    string       name;
    logic [31:0] lo;
    logic [31:0] hi;
    bit          checkHi;
    logic        hiWrite;
    logic [1:0]  flags;
    logic        dbz;
    int          latency;
    int          acceptCyc;
  } exp_t;

  exp_t        expQ[$];
  exp_t        mon;
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  logic [31:0] lastLo   = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Behavioural reference: plain 64-bit arithmetic on the operation's meaning.
  function automatic exp_t model(input string name, input logic [5:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] cLo, input logic [31:0] cHi);
    exp_t        e;
    logic [63:0] p;
    logic [63:0] c;
    longint      sa, sb;
    logic [31:0] mb;
    int          iters;
    e.name = name; e.lo = '0; e.hi = '0; e.checkHi = 0; e.hiWrite = 0;
    e.dbz = 0; e.latency = 35; e.acceptCyc = 0;
    c  = {cHi, cLo};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    case (op)
      OP_MUL:   e.lo = a * b;
      OP_MLA:   e.lo = cLo + a * b;
      OP_MLS:   e.lo = cLo - a * b;
      OP_UMULL: p = {32'd0, a} * {32'd0, b};
      OP_UMLAL: p = c + {32'd0, a} * {32'd0, b};
      OP_SMULL: p = sa * sb;
      OP_SMLAL: p = c + sa * sb;
      OP_UDIV, OP_SDIV: begin
        if (b == 0) begin
          e.lo = '0; e.dbz = 1; e.latency = 3;
        end else if (op == OP_UDIV) begin
          e.lo = a / b; e.hi = a % b; e.checkHi = 1;
        end else begin
          e.lo = 32'(sa / sb); e.hi = 32'(sa % sb); e.checkHi = 1;
        end
      end
      default: ;
    endcase
    if (is_long(op)) begin
      e.lo = p[31:0]; e.hi = p[63:32]; e.checkHi = 1; e.hiWrite = 1;
      e.flags = {p[63], p == 64'd0};
    end else begin
      e.flags = {e.lo[31], e.lo == 32'd0};
    end
`ifdef MULDIV_EARLY_TERM_EN
    if (!is_div(op)) begin
      mb = (is_signed(op) && b[31]) ? -b : b;
      iters = 1;
      for (int i = 1; i < 32; i++) if ((mb >> i) != 0) iters = i + 1;
      e.latency = 3 + iters;
    end
`else
    mb = b; iters = 32;
`endif
    return e;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'($urandom_range(0, 15));
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    if (reset === 1'b1 && bus.DoneM === 1'b1) begin
      if (expQ.size() == 0) begin
        check("unexpected_done", bus.DoneM, 1'b0);
      end else begin
        mon = expQ.pop_front();
        check({mon.name, "_lo"}, bus.ResultLoM, mon.lo);
        if (mon.checkHi) check({mon.name, "_hi"}, bus.ResultHiM, mon.hi);
        check({mon.name, "_hiwrite"}, bus.HiWriteM, mon.hiWrite);
        check({mon.name, "_flags"}, bus.FlagsM, mon.flags);
        check({mon.name, "_dbz"}, bus.DivByZeroM, mon.dbz);
        check({mon.name, "_latency"}, cyc - mon.acceptCyc, mon.latency);
        check({mon.name, "_stall_in_done"}, bus.StallMD, 1'b0);
        lastLo = mon.lo;
      end
    end
  end

  task automatic driveStart(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] cLo, input logic [31:0] cHi);
    @(posedge clk); #1;
    bus.StartE = 1'b1; bus.FlushE = 1'b0; bus.ALUControlE = op;
    bus.SrcAE = a; bus.SrcBE = b; bus.AccLoE = cLo; bus.AccHiE = cHi;
  endtask

  // Issue one op, keep stray starts on the bus while busy, wait for DoneM.
  task automatic runOp(input string name, input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] cLo, input logic [31:0] cHi);
    exp_t e;
    int   stallCnt;
    bit   seen;
    e = model(name, op, a, b, cLo, cHi);
    driveStart(op, a, b, cLo, cHi);
    e.acceptCyc = cyc;
    expQ.push_back(e);
    @(negedge clk);
    check({name, "_accept_stall"}, bus.StallMD, 1'b1);
    stallCnt = bus.StallMD ? 1 : 0;
    seen = 0;
    for (int w = 0; w < 200 && !seen; w++) begin
      @(posedge clk); #1;
      bus.StartE      = 1'($urandom_range(0, 1));
      bus.ALUControlE = OP_MUL + 6'($urandom_range(0, 8));
      bus.SrcAE = $urandom; bus.SrcBE = $urandom;
      bus.AccLoE = $urandom; bus.AccHiE = $urandom;
      @(negedge clk);
      if (bus.DoneM) seen = 1;
      else if (bus.StallMD) stallCnt++;
    end
    bus.StartE = 1'b0;
    if (!seen) check({name, "_timeout"}, bus.DoneM, 1'b1);
    check({name, "_stall_cycles"}, stallCnt, e.latency);
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_stall"}, bus.StallMD, 1'b0);
    check({tag, "_done"}, bus.DoneM, 1'b0);
    check({tag, "_lo"}, bus.ResultLoM, 32'd0);
    check({tag, "_hi"}, bus.ResultHiM, 32'd0);
    check({tag, "_hiwrite"}, bus.HiWriteM, 1'b0);
    check({tag, "_flags"}, bus.FlagsM, 2'b00);
    check({tag, "_dbz"}, bus.DivByZeroM, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] op;
    bus.StartE = 0; bus.FlushE = 0; bus.ALUControlE = '0;
    bus.SrcAE = '0; bus.SrcBE = '0; bus.AccLoE = '0; bus.AccHiE = '0;
    repeat (3) @(negedge clk);
    checkAllZero("in_reset");
    reset = 1'b1;
    @(negedge clk);
    checkAllZero("after_reset");

    runOp("umull_max",  OP_UMULL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0);
    runOp("smlal_zero", OP_SMLAL, 32'hFFFF_FFFD, 32'd7, 32'h15, 32'd0);
    runOp("sdiv_neg",   OP_SDIV,  32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0);
    runOp("sdiv_ovf",   OP_SDIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0);
    runOp("udiv_zero",  OP_UDIV,  32'd5, 32'd0, 32'd0, 32'd0);
    runOp("mls",        OP_MLS,   32'd4, 32'd5, 32'd100, 32'd0);
    runOp("mul_b2b",    OP_MUL,   32'd6, 32'd7, 32'd0, 32'd0);
    runOp("mul_3x2",    OP_MUL,   32'd3, 32'd2, 32'd0, 32'd0);
    runOp("sdiv_zero",  OP_SDIV,  32'hFFFF_FFF0, 32'd0, 32'd0, 32'd0);

    for (int i = 0; i < 40; i++) begin
      op = OP_MUL + 6'($urandom_range(0, 8));
      runOp($sformatf("rnd%0d", i), op, pick(), pick(), $urandom, $urandom);
    end

    // Out-of-range codes must not start anything.
    driveStart(6'b100110, 32'd9, 32'd9, 32'd0, 32'd0);
    @(negedge clk);
    check("oor_low_stall", bus.StallMD, 1'b0);
    driveStart(6'b110000, 32'd9, 32'd9, 32'd0, 32'd0);
    @(negedge clk);
    check("oor_high_stall", bus.StallMD, 1'b0);

    // Valid start together with a flush is not captured.
    driveStart(OP_MUL, 32'd9, 32'd9, 32'd0, 32'd0);
    bus.FlushE = 1'b1;
    @(negedge clk);
    check("idle_flush_stall", bus.StallMD, 1'b0);
    @(posedge clk); #1;
    bus.StartE = 1'b0; bus.FlushE = 1'b0;
    @(negedge clk);
    check("idle_flush_no_prep", bus.StallMD, 1'b0);

    // Flush at T+10 of a multiply: idle at T+11, no DoneM, results untouched.
    driveStart(OP_MUL, 32'h1234_5678, 32'h8000_0001, 32'd0, 32'd0);
    @(posedge clk); #1;
    bus.StartE = 1'b0;
    repeat (9) @(posedge clk);
    #1 bus.FlushE = 1'b1;
    @(negedge clk);
    check("flush_t10_stall", bus.StallMD, 1'b1);
    @(posedge clk); #1;
    bus.FlushE = 1'b0;
    @(negedge clk);
    check("flush_t11_stall", bus.StallMD, 1'b0);
    check("flush_t11_done", bus.DoneM, 1'b0);
    check("flush_keeps_lo", bus.ResultLoM, lastLo);
    repeat (40) @(negedge clk);

    runOp("mul_pre_reset", OP_MUL, 32'd6, 32'd7, 32'd0, 32'd0);

    // Asynchronous reset at T+10 clears everything immediately.
    driveStart(OP_MUL, 32'h1234_5678, 32'h8000_0001, 32'd0, 32'd0);
    @(posedge clk); #1;
    bus.StartE = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b0;
    #1 checkAllZero("async_reset");
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);

    runOp("umlal_after_reset", OP_UMLAL, $urandom, $urandom, $urandom, $urandom);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
